// File: rtl/meas_lut_pkg.sv
// Shared definitions for the measurement-outcome lookup controller.
// Holds the sequencer state encoding and the default geometry used as
// parameter defaults by meas_lut_ctrl and meas_lut_cfg_mem.
package meas_lut_pkg;

  localparam int N_CORES_DEF   = 5;
  localparam int N_MEAS_DEF    = N_CORES_DEF;
  localparam int LUT_DEPTH     = 2 ** N_MEAS_DEF;
  localparam int TIMEOUT_W_DEF = 16;
  localparam int OVR_W_DEF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_LOOKUP  = 2'd2,
    ST_PRESENT = 2'd3
  } state_e;

endpackage

// File: rtl/meas_lut_cfg_mem.sv
// Outcome lookup table: 2**ADDR_W entries of DATA_W bits, one write port,
// one registered read port. rdata holds its value whenever rd_en is low,
// so it can drive the presented trigger word directly.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset (clears every entry)
//   wen/waddr/wdata  write port
//   rd_en/raddr      read request; rdata updates on the following edge
//   rdata            registered read data
module meas_lut_cfg_mem
  import meas_lut_pkg::*;
#(
  parameter int ADDR_W = N_MEAS_DEF,
  parameter int DATA_W = N_CORES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the table is small and must read back as all-zero after reset, so
  // it is built from resettable flops rather than a RAM macro without reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (wen)   mem[waddr] <= wdata;
      if (rd_en) rdata      <= mem[raddr];
    end
  end

endmodule

// File: rtl/meas_lut_ctrl.sv
// Measurement-outcome LUT sequencer. Collects per-channel measurement bits
// selected by a writable mask, looks the assembled address up in the
// outcome table and presents the trigger word to the cores over
// valid/ready. Configuration is only accepted while idle.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   enable                        run collection; low returns to idle
//   cfg_lut_wen/cfg_addr/cfg_data table write
//   cfg_mask_wen/cfg_mask         required-channel mask write
//   cfg_err                       sticky: config write while not idle
//   timeout_cycles                collection timeout (0 = disabled)
//   meas/meas_valid               per-channel outcome bits and strobes
//   lut_out/lut_out_valid/ready   trigger word handshake
//   busy                          sequencer not idle
//   timeout_err                   sticky: a collection timed out
//   clear_err                     clears cfg_err, timeout_err, overrun_cnt
//   overrun_cnt                   saturating dropped/duplicate strobe count
module meas_lut_ctrl
  import meas_lut_pkg::*;
#(
  parameter int N_CORES   = N_CORES_DEF,
  parameter int N_MEAS    = N_CORES,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF,
  parameter int OVR_W     = OVR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 cfg_lut_wen,
  input  logic                 cfg_mask_wen,
  input  logic [N_MEAS-1:0]    cfg_addr,
  input  logic [N_CORES-1:0]   cfg_data,
  input  logic [N_MEAS-1:0]    cfg_mask,
  output logic                 cfg_err,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic [N_MEAS-1:0]    meas,
  input  logic [N_MEAS-1:0]    meas_valid,
  output logic [N_CORES-1:0]   lut_out,
  output logic                 lut_out_valid,
  input  logic                 lut_out_ready,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 clear_err,
  output logic [OVR_W-1:0]     overrun_cnt
);

  state_e               state, state_next;
  logic [N_MEAS-1:0]    mask;
  logic [N_MEAS-1:0]    coll_valid, coll_valid_next;
  logic [N_MEAS-1:0]    coll_addr, coll_addr_next;
  logic                 tmo_active, tmo_active_next;
  logic [TIMEOUT_W-1:0] tmo_cnt, tmo_cnt_next;
  logic [OVR_W-1:0]     ovr_base, ovr_next;
  logic [N_MEAS-1:0]    new_valid, first_valid;
  logic                 cfg_wr, cfg_ok, dup, complete, tmo_hit, accept;
  logic                 ovr_inc, tmo_set;

  assign cfg_wr      = cfg_lut_wen | cfg_mask_wen;
  assign cfg_ok      = (state == ST_IDLE);
  assign new_valid   = meas_valid & mask;
  assign first_valid = new_valid & ~coll_valid;
  assign dup         = |(new_valid & coll_valid);
  assign complete    = ((coll_valid | new_valid) == mask);
  assign accept      = lut_out_valid & lut_out_ready;
  // ">=" rather than "==" so lowering timeout_cycles mid-collection still fires.
  assign tmo_hit     = tmo_active && (timeout_cycles != '0) &&
                       (tmo_cnt >= timeout_cycles - TIMEOUT_W'(1));
  assign busy        = (state != ST_IDLE);

  meas_lut_cfg_mem #(
    .ADDR_W (N_MEAS),
    .DATA_W (N_CORES)
  ) u_cfg_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wen     (cfg_lut_wen & cfg_ok),
    .waddr   (cfg_addr),
    .wdata   (cfg_data),
    .rd_en   (state == ST_LOOKUP),
    .raddr   (coll_addr),
    .rdata   (lut_out)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (enable && mask != '0) state_next = ST_COLLECT;
      ST_COLLECT: if (!enable)              state_next = ST_IDLE;
                  else if (complete)        state_next = ST_LOOKUP;
      // A pending word is always delivered, even if enable drops meanwhile.
      ST_LOOKUP:  state_next = ST_PRESENT;
      ST_PRESENT: if (accept) state_next = enable ? ST_COLLECT : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Collection registers, timeout tracking and overrun events. A cycle with
  // any duplicate or dropped masked strobe counts as one overrun event.
  always_comb begin
    coll_valid_next = coll_valid;
    coll_addr_next  = coll_addr;
    tmo_active_next = tmo_active;
    tmo_cnt_next    = tmo_cnt;
    tmo_set         = 1'b0;
    ovr_inc         = 1'b0;
    unique case (state)
      ST_COLLECT: begin
        if (!enable) begin
          coll_valid_next = '0;
          coll_addr_next  = '0;
          tmo_active_next = 1'b0;
          tmo_cnt_next    = '0;
        end else begin
          ovr_inc = dup;
          if (complete) begin
            coll_valid_next = mask;
            coll_addr_next  = coll_addr | (meas & first_valid);
            tmo_active_next = 1'b0;
            tmo_cnt_next    = '0;
          end else if (tmo_hit) begin
            tmo_set         = 1'b1;
            coll_valid_next = '0;
            coll_addr_next  = '0;
            tmo_active_next = 1'b0;
            tmo_cnt_next    = '0;
          end else begin
            coll_valid_next = coll_valid | first_valid;
            coll_addr_next  = coll_addr | (meas & first_valid);
            if (tmo_active) begin
              if (tmo_cnt != '1) tmo_cnt_next = tmo_cnt + TIMEOUT_W'(1);
            end else if (new_valid != '0) begin
              tmo_active_next = 1'b1;
              tmo_cnt_next    = '0;
            end
          end
        end
      end
      ST_LOOKUP: ovr_inc = (new_valid != '0);
      ST_PRESENT: begin
        ovr_inc = (new_valid != '0);
        if (accept) begin
          coll_valid_next = '0;
          coll_addr_next  = '0;
        end
      end
      default: begin
        coll_valid_next = '0;
        coll_addr_next  = '0;
        tmo_active_next = 1'b0;
        tmo_cnt_next    = '0;
      end
    endcase
  end

  // A new overrun event in the clearing cycle leaves a count of one.
  always_comb begin
    ovr_base = clear_err ? '0 : overrun_cnt;
    ovr_next = ovr_base;
    if (ovr_inc && ovr_base != '1) ovr_next = ovr_base + OVR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask          <= '0;
      coll_valid    <= '0;
      coll_addr     <= '0;
      tmo_active    <= 1'b0;
      tmo_cnt       <= '0;
      lut_out_valid <= 1'b0;
      cfg_err       <= 1'b0;
      timeout_err   <= 1'b0;
      overrun_cnt   <= '0;
    end else begin
      if (cfg_mask_wen && cfg_ok) mask <= cfg_mask;
      coll_valid    <= coll_valid_next;
      coll_addr     <= coll_addr_next;
      tmo_active    <= tmo_active_next;
      tmo_cnt       <= tmo_cnt_next;
      // Raised one cycle into PRESENT, once the table read has landed.
      lut_out_valid <= (state == ST_PRESENT) && !accept;
      if (cfg_wr && !cfg_ok) cfg_err <= 1'b1;
      else if (clear_err)    cfg_err <= 1'b0;
      if (tmo_set)           timeout_err <= 1'b1;
      else if (clear_err)    timeout_err <= 1'b0;
      overrun_cnt   <= ovr_next;
    end
  end

endmodule
